// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the execute-stage units.
// Holds the divider op encoding, the step-counter width and the fixed special-case results.
package rv32_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    // Wide enough to hold RV_XLEN itself, the initial step count.
    localparam int DIV_CNT_W = $clog2(RV_XLEN) + 1;

    localparam logic [RV_XLEN-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [RV_XLEN-1:0] DIV_OVF_QUOT  = {1'b1, {(RV_XLEN-1){1'b0}}};
    localparam logic [RV_XLEN-1:0] DIV_OVF_REM   = '0;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU in the execute stage.
// BusyE stalls the pipeline while the divide runs; the result is presented for one cycle in DONE.
module div_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  div_op_t         DivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] DivResultE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    div_state_t             stateReg, stateNext;
    logic [DIV_CNT_W-1:0]   cntReg;
    logic [XLEN-1:0]        remReg, quotReg, divisorReg;
    div_op_t                opReg;
    logic                   negQuotReg, negRemReg;
    logic                   doneReg;
    logic [XLEN-1:0]        resultReg;

    // Start-cycle decode on the forwarded operands.
    logic            opSigned, aNeg, bNeg, divByZero, signedOvf, isSpecial;
    logic [XLEN-1:0] magA, magB, specialResult;

    assign opSigned  = ~DivOpE[0];
    assign aNeg      = opSigned & SrcAE[XLEN-1];
    assign bNeg      = opSigned & SrcBE[XLEN-1];
    assign magA      = aNeg ? ('0 - SrcAE) : SrcAE;
    assign magB      = bNeg ? ('0 - SrcBE) : SrcBE;
    assign divByZero = (SrcBE == '0);
    assign signedOvf = opSigned & (SrcAE == DIV_OVF_QUOT) & (&SrcBE);
    assign isSpecial = divByZero | signedOvf;

    always_comb begin
        specialResult = DIV_OVF_QUOT;
        if (divByZero)
            specialResult = DivOpE[1] ? SrcAE : DIV_ZERO_QUOT;
        else if (DivOpE[1])
            specialResult = DIV_OVF_REM;
    end

    // One restoring step: the shifted remainder can exceed XLEN bits, so the trial is XLEN+1 wide.
    logic [XLEN:0]   remWide, trial;
    logic            trialOk;
    logic [XLEN-1:0] remStep, quotStep, quotFix, remFix, finalResult;

    assign remWide     = {remReg, quotReg[XLEN-1]};
    assign trial       = remWide - {1'b0, divisorReg};
    assign trialOk     = ~trial[XLEN];
    assign remStep     = trialOk ? trial[XLEN-1:0] : remWide[XLEN-1:0];
    assign quotStep    = {quotReg[XLEN-2:0], trialOk};
    assign quotFix     = negQuotReg ? ('0 - quotStep) : quotStep;
    assign remFix      = negRemReg ? ('0 - remStep) : remStep;
    assign finalResult = opReg[1] ? remFix : quotFix;

    always_comb begin
        stateNext = stateReg;
        BusyE     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (StartE) begin
                    BusyE     = 1'b1;
                    stateNext = isSpecial ? DONE : RUN;
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (cntReg == DIV_CNT_W'(1))
                    stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntReg     <= '0;
            remReg     <= '0;
            quotReg    <= '0;
            divisorReg <= '0;
            opReg      <= DIV_OP_DIV;
            negQuotReg <= 1'b0;
            negRemReg  <= 1'b0;
            doneReg    <= 1'b0;
            resultReg  <= '0;
        end else begin
            doneReg <= (stateNext == DONE);
            case (stateReg)
                IDLE: begin
                    if (StartE) begin
                        opReg      <= DivOpE;
                        negQuotReg <= aNeg ^ bNeg;
                        negRemReg  <= aNeg;
                        divisorReg <= magB;
                        quotReg    <= magA;
                        remReg     <= '0;
                        if (isSpecial)
                            resultReg <= specialResult;
                        else
                            cntReg <= DIV_CNT_W'(XLEN);
                    end
                end
                RUN: begin
                    remReg  <= remStep;
                    quotReg <= quotStep;
                    cntReg  <= cntReg - DIV_CNT_W'(1);
                    if (cntReg == DIV_CNT_W'(1))
                        resultReg <= finalResult;
                end
                default: ;
            endcase
        end
    end

    assign DivDoneE   = doneReg;
    assign DivResultE = resultReg;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider for the execute stage. It handles DIV, DIVU, REM and REMU with a restoring radix-2 algorithm. It drives the BusyE structural-hazard signal consumed by the hazard unit, which holds F/D/E (StallF/StallD/StallE) and bubbles M (FlushM) while BusyE is high. The result is muxed into the E-stage result path in the cycle BusyE falls.

## Interface

Parameters:
- XLEN, 32, operand and result width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StartE  in  1  a divide op occupies E. Stays high for the whole residency while E is stalled.
- DivOpE  in  2  div_op_t: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcAE  in  XLEN  dividend, after forwarding.
- SrcBE  in  XLEN  divisor, after forwarding.
- BusyE  out  1  structural stall request to the hazard unit.
- DivDoneE  out  1  one-cycle strobe: DivResultE is valid.
- DivResultE  out  XLEN  quotient or remainder.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, StartE=0: stay in IDLE; BusyE=0.
- IDLE, StartE=1 (start cycle):
  - BusyE=1, combinational.
  - Capture DivOpE, sign flags, |SrcAE| and |SrcBE|. Magnitudes are used only for signed ops.
  - Capture is mandatory: FlushM bubbles M after this cycle, so forwarded operands disappear.
  - Special cases go straight to DONE. Otherwise load cnt=XLEN and go to RUN.
- Special cases:
  - Divisor 0: quotient all ones; remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000; remainder 0.
- RUN: BusyE=1. Each cycle performs one restoring step:
  - Shift {rem,quot} left by 1.
  - trial = rem − divisor, computed XLEN+1 wide.
  - If trial ≥ 0: rem=trial and quot[0]=1.
  - Decrement cnt. When cnt reaches 1, go to DONE.
- DONE: BusyE=0, DivDoneE=1, DivResultE valid. Always return to IDLE next cycle.
  - StartE is still high in DONE (same instruction) and must not restart the FSM.
- Sign fix-up, registered on the RUN→DONE edge:
  - Quotient negated if signed and sign(a)≠sign(b).
  - Remainder negated if signed and sign(a)=1.
  - Result takes the sign of the dividend, per RISC-V.
- Arithmetic is two's complement modulo 2^XLEN.
  - |0x80000000| = 0x80000000, which is correct as an unsigned magnitude.
- StartE dropping while in RUN (no legal source exists) is ignored; the operation completes.

## Timing

- Reset values:
  - State IDLE; cnt=0; rem, quot and captured registers 0.
  - DivDoneE=0; DivResultE=0.
  - BusyE=0 unless StartE=1, because BusyE is combinational in IDLE.
- Normal op: start cycle, then 32 RUN cycles, then DONE. BusyE is high for 33 cycles; E residency is 34 cycles.
- Special case: BusyE high for 1 cycle; DONE in the next cycle; residency 2 cycles.
- Back-to-back divides: the second StartE appears the cycle after DONE. IDLE accepts it with no dead cycle.
- DivResultE and DivDoneE are registered.
- BusyE is not registered: (state==IDLE & StartE) | (state==RUN).
- Reset asserted mid-RUN: immediately IDLE, BusyE=0, and no DivDoneE pulse.

## Structure

- Shared package rv32_pkg holds:
  - div_op_t enum.
  - Constant DIV_CNT_W = $clog2(XLEN)+1.
  - The divide-by-zero and overflow result constants.
- No sub-module: the restoring step is a single inline subtract-and-mux.
- Target size is about 150 lines.

## Test plan

- DIV 100 / 7: BusyE high for exactly 33 cycles, then DivDoneE=1 for one cycle with DivResultE=14.
- REM −7 / 2: DivResultE=0xFFFFFFFF (−1). DIV −7 / 2 gives 0xFFFFFFFD (−3).
- DIVU 5 / 0: BusyE high for 1 cycle, then DivResultE=0xFFFFFFFF. REMU 5 / 0 gives 5.
- REM 0x80000000 / 0xFFFFFFFF: DivResultE=0. DIV gives 0x80000000. Both with a 2-cycle residency.
- Two DIVU ops, 0xFFFFFFFF/16 then 9/3, with StartE held through DONE: no restart in DONE. Results are 0x0FFFFFFF, then 3 exactly 34 cycles later.
- rst_n pulsed low at RUN cycle 10: BusyE=0 immediately, no DivDoneE pulse. A new StartE after release gives a correct result.
